// File: rtl/seq_div_16.sv
// seq_div_16: 16-bit unsigned restoring divider, one quotient bit per cycle.
// A zero divisor skips the iteration and reports div_by_zero with the result.
module seq_div_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom
    logic [W-1:0]    dvd_q;
    logic [W-1:0]    dvs_q;
    logic [W-1:0]    rem_q;
    logic [CW-1:0]   cnt;

    logic            accept_c;
    logic            zero_c;
    logic            last_c;
    logic [W:0]      shifted_c;
    logic [W+1:0]    diff_c;
    logic            qbit_c;
    logic [W-1:0]    rem_next_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        zero_c     = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (divisor == '0) begin
                        zero_c     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == CW'(W - 1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    always_comb begin
        shifted_c  = {rem_q, dvd_q[W-1]};
        diff_c     = {1'b0, shifted_c} - {2'b00, dvs_q};
        qbit_c     = ~diff_c[W+1];
        rem_next_c = qbit_c ? diff_c[W-1:0] : shifted_c[W-1:0];
    end

    // Operand latches, iteration registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= last_c | zero_c;
            if (accept_c) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt   <= '0;
                if (zero_c) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                dvd_q <= {dvd_q[W-2:0], qbit_c};
                rem_q <= rem_next_c;
                cnt   <= cnt + CW'(1);
                if (last_c) begin
                    quotient    <= {dvd_q[W-2:0], qbit_c};
                    remainder   <= rem_next_c;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div_16.sv
// tb_seq_div_16: directed vectors for seq_div_16 with an arithmetic reference model.
module tb_seq_div_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_div_16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: results from / and %, timing as a countdown of run cycles
    int          m_left = 0;
    logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic        model_on = 1'b0;

    // Advance the model on each rising edge using the inputs the DUT sees
    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_q = '0; m_r = '0;
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
            model_on = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_q = p_q; m_r = p_r; m_dbz = 1'b0;
            end
        end else if (start) begin
            if (divisor == 16'd0) begin
                m_done = 1'b1; m_busy = 1'b0;
                m_q = 16'hFFFF; m_r = dividend; m_dbz = 1'b1;
            end else begin
                p_q = dividend / divisor;
                p_r = dividend % divisor;
                m_left = 16; m_busy = 1'b1; m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
            chk("cyc_quotient", 32'(quotient), 32'(m_q));
            chk("cyc_remainder", 32'(remainder), 32'(m_r));
        end
    end

    // Start a division at the current negedge (cycle 0) and check the result pulse
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edz, input int lat, input string nm);
        int n;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        chk({nm, "_quotient"}, 32'(quotient), 32'(eq));
        chk({nm, "_remainder"}, 32'(remainder), 32'(er));
        chk({nm, "_dbz"}, 32'(div_by_zero), 32'(edz));
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        // Start in the first cycle after reset release
        do_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, "d100_7");
        do_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, "dffff_1");
        do_div(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, "d3_10");
        do_div(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17, "dffff_ffff");
        do_div(16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, 17, "d65535_255");
        do_div(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, "d5_0");
        do_div(16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 17, "d9_2");

        // Start pulse during RUN must be ignored
        dividend = 16'd50; divisor = 16'd3; start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            start = (n == 5);
            if (n == 5) begin
                dividend = 16'd1; divisor = 16'd1;
            end
        end
        chk("ignore_latency", 32'(n), 32'd17);
        chk("ignore_quotient", 32'(quotient), 32'd16);
        chk("ignore_remainder", 32'(remainder), 32'd2);
        @(negedge clk);

        // Reset in cycle 8 aborts the division without a done pulse
        dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        repeat (3) @(negedge clk);
        do_div(16'd17, 16'd5, 16'd3, 16'd2, 1'b0, 17, "d17_5");

        // Start held high through DONE: back-to-back acceptance
        dividend = 16'd200; divisor = 16'd9; start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_latency", 32'(n), 32'd17);
        chk("b2b_first_quotient", 32'(quotient), 32'd22);
        chk("b2b_first_remainder", 32'(remainder), 32'd2);
        dividend = 16'd60000; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        n++;
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_latency", 32'(n), 32'd34);
        chk("b2b_second_quotient", 32'(quotient), 32'd8571);
        chk("b2b_second_remainder", 32'(remainder), 32'd3);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
